dino_collision_detect: RTL and testbench

- Sits directly downstream of the VGA sprite renderer.
- Takes the renderer's per-cycle sprite-visibility flags together with the hcount/vcount raster position.
- Counts the clock cycles per frame in which the dino and each obstacle sprite overlap, and commits the counts at end of active video.
- Raises sticky hit flags and an interrupt that the game software reads over the same Avalon-style register bus used by the renderer.

---
 rtl/dino_collision_detect_if.sv | 15 +
 rtl/dino_collision_detect.sv | 126 ++++++++++++
 tb/tb_dino_collision_detect.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/dino_collision_detect_if.sv
// Avalon-style register bus between game software and the collision detector.
// A transfer happens on any clock edge where chipselect is high together with
// write or read; there is no wait state. readdata is registered: it holds the
// addressed value from the edge after the read strobe until the next read.
interface dino_collision_detect_if;
  logic        chipselect;
  logic        write;
  logic        read;
  logic [2:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output chipselect, write, read, address, writedata, input readdata);
  modport slave  (input chipselect, write, read, address, writedata, output readdata);
endinterface

// File: rtl/dino_collision_detect.sv
// Per-frame dino/obstacle overlap counter with sticky hit flags and a level irq.
// Counts are committed once per frame when the raster reaches the first blank line.
module dino_collision_detect #(
  parameter int NUM_OBS    = 4,
  parameter int CNT_W      = 16,
  parameter int VACTIVE    = 480,
  parameter int DEF_THRESH = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [10:0]        hcount,
  input  logic [9:0]         vcount,
  input  logic               blank_n,
  input  logic               dino_vis,
  input  logic [NUM_OBS-1:0] obs_vis,
  dino_collision_detect_if.slave bus,
  output logic               irq,
  output logic [1:0]         o_dbg_state
);

  typedef enum logic [1:0] {IDLE, ARM, ACCUM, COMMIT} state_t;

  state_t             r_state, w_next;
  logic [1:0]         r_ctrl;
  logic [NUM_OBS-1:0] r_hit;
  logic [15:0]        r_frame_cnt;
  logic [CNT_W-1:0]   r_thresh;
  logic [CNT_W-1:0]   r_acc [NUM_OBS];
  logic [CNT_W-1:0]   r_ovl [NUM_OBS];
  logic [31:0]        r_readdata;
  logic               r_irq;

  logic               w_enable, w_sof, w_eof, w_acc_en, w_commit, w_acc_clr;
  logic               w_wr, w_rd;
  logic [NUM_OBS-1:0] w_w1c, w_set;
  logic [31:0]        w_rdata;
  logic               w_unused_bits;

  assign w_enable = r_ctrl[0];
  assign w_sof    = (hcount == 11'd0) && (vcount == 10'd0);
  assign w_eof    = (hcount == 11'd0) && (vcount == 10'(VACTIVE));
  // The start-of-frame cycle that moves ARM to ACCUM is already part of the frame.
  assign w_acc_en  = w_enable && ((r_state == ACCUM) || (r_state == ARM && w_sof));
  assign w_commit  = w_enable && (r_state == COMMIT);
  assign w_acc_clr = !w_enable || (r_state == IDLE) || (r_state == COMMIT);
  assign w_wr      = bus.chipselect && bus.write;
  assign w_rd      = bus.chipselect && bus.read;
  assign w_w1c     = (w_wr && bus.address == 3'd1) ? bus.writedata[NUM_OBS-1:0] : '0;
  assign w_unused_bits = &{1'b0, bus.writedata[31:CNT_W]};

  always_comb begin
    w_next = r_state;
    if (!w_enable) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_next = ARM;
        ARM:     if (w_sof) w_next = ACCUM;
        ACCUM:   if (w_eof) w_next = COMMIT;
        COMMIT:  w_next = ARM;
        default: w_next = IDLE;
      endcase
    end
  end

  always_comb begin
    w_set = '0;
    for (int i = 0; i < NUM_OBS; i++) begin
      w_set[i] = w_commit && (r_acc[i] >= r_thresh);
    end
  end

  always_comb begin
    w_rdata = '0;
    case (bus.address)
      3'd0: w_rdata[1:0]         = r_ctrl;
      3'd1: w_rdata[NUM_OBS-1:0] = r_hit;
      3'd2: w_rdata[15:0]        = r_frame_cnt;
      3'd7: w_rdata[CNT_W-1:0]   = r_thresh;
      default: begin
        for (int i = 0; i < NUM_OBS; i++) begin
          if (bus.address == 3'(3 + i)) w_rdata[CNT_W-1:0] = r_ovl[i];
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_ctrl      <= '0;
      r_hit       <= '0;
      r_frame_cnt <= '0;
      r_thresh    <= CNT_W'(DEF_THRESH);
      r_readdata  <= '0;
      r_irq       <= 1'b0;
      for (int i = 0; i < NUM_OBS; i++) begin
        r_acc[i] <= '0;
        r_ovl[i] <= '0;
      end
    end else begin
      r_state <= w_next;
      if (w_wr && bus.address == 3'd0) r_ctrl   <= bus.writedata[1:0];
      if (w_wr && bus.address == 3'd7) r_thresh <= bus.writedata[CNT_W-1:0];
      // A commit setting a bit beats a software clear of the same bit.
      r_hit <= (r_hit & ~w_w1c) | w_set;
      if (w_commit) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (w_rd) r_readdata <= w_rdata;
      r_irq <= r_ctrl[1] && (|r_hit);
      for (int i = 0; i < NUM_OBS; i++) begin
        if (w_commit) r_ovl[i] <= r_acc[i];
        if (w_acc_clr) begin
          r_acc[i] <= '0;
        end else if (w_acc_en && blank_n && dino_vis && obs_vis[i] &&
                     (r_acc[i] != {CNT_W{1'b1}})) begin
          r_acc[i] <= r_acc[i] + CNT_W'(1);
        end
      end
    end
  end

  assign bus.readdata = r_readdata;
  assign irq          = r_irq;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_dino_collision_detect.sv
// Directed and randomized frames against a per-frame reference of the register map.
module tb_dino_collision_detect;
  localparam int NUM_OBS = 4;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic [10:0]        hcount = '0;
  logic [9:0]         vcount = 10'd490;
  logic               blank_n = 1'b0;
  logic               dino_vis = 1'b0;
  logic [NUM_OBS-1:0] obs_vis = '0;
  logic               irq;
  logic [1:0]         dbg_state;

  dino_collision_detect_if bus ();

  dino_collision_detect #(.NUM_OBS(NUM_OBS), .CNT_W(16), .VACTIVE(480), .DEF_THRESH(4)) dut (
    .clk(clk), .reset_n(reset_n), .hcount(hcount), .vcount(vcount), .blank_n(blank_n),
    .dino_vis(dino_vis), .obs_vis(obs_vis), .bus(bus), .irq(irq), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          exp_ovl [NUM_OBS];
  logic [3:0]  exp_hit;
  logic [15:0] exp_frames;
  logic [15:0] exp_thresh;
  logic [1:0]  exp_ctrl;
  logic [31:0] rdat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_raster(input int h, input int v, input logic b, input logic d,
                            input logic [3:0] o);
    hcount = 11'(h); vcount = 10'(v); blank_n = b; dino_vis = d; obs_vis = o;
  endtask

  task automatic park();
    set_raster(5, 490, 1'b0, 1'b0, 4'h0);
  endtask

  task automatic reset_model();
    for (int i = 0; i < NUM_OBS; i++) exp_ovl[i] = 0;
    exp_hit = '0; exp_frames = '0; exp_thresh = 16'd4; exp_ctrl = '0;
  endtask

  task automatic model_write(input logic [2:0] a, input logic [31:0] d);
    if (a == 3'd0) exp_ctrl = d[1:0];
    if (a == 3'd1) exp_hit = exp_hit & ~d[3:0];
    if (a == 3'd7) exp_thresh = d[15:0];
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = a; bus.writedata = d;
    tick();
    bus.chipselect = 1'b0; bus.write = 1'b0;
    model_write(a, d);
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = a;
    tick();
    bus.chipselect = 1'b0; bus.read = 1'b0;
    d = bus.readdata;
  endtask

  task automatic check_all(input string step);
    logic [31:0] d;
    rd(3'd0, d); check({step, ".ctrl"}, d, {30'd0, exp_ctrl});
    rd(3'd1, d); check({step, ".status"}, d, {28'd0, exp_hit});
    rd(3'd2, d); check({step, ".frame_cnt"}, d, {16'd0, exp_frames});
    for (int i = 0; i < NUM_OBS; i++) begin
      rd(3'(3 + i), d);
      check($sformatf("%s.ovl%0d", step, i), d, 32'(exp_ovl[i]));
    end
    rd(3'd7, d); check({step, ".thresh"}, d, {16'd0, exp_thresh});
    check({step, ".irq"}, {31'd0, irq}, {31'd0, exp_ctrl[1] & (|exp_hit)});
  endtask

  // One full frame: start-of-frame, n active cycles, blanked overlap, end-of-active, commit.
  task automatic run_frame(input int n, input logic [3:0] mask, input bit rnd,
                           input int mid_thresh, input logic [3:0] w1c);
    int         cnt [NUM_OBS];
    logic       d;
    logic [3:0] o;
    for (int i = 0; i < NUM_OBS; i++) cnt[i] = 0;
    park(); tick();
    set_raster(0, 0, 1'b1, 1'b0, 4'h0); tick();
    for (int k = 0; k < n; k++) begin
      d = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      o = rnd ? 4'($urandom_range(0, 15)) : mask;
      set_raster(10 + k % 1000, 1 + k / 1000, 1'b1, d, o);
      if (mid_thresh >= 0 && k == n / 2) begin
        wr(3'd7, 32'(mid_thresh));
      end else begin
        tick();
      end
      for (int i = 0; i < NUM_OBS; i++) if (d && o[i]) cnt[i]++;
    end
    for (int k = 0; k < 8; k++) begin
      set_raster(1280 + k, 200, 1'b0, 1'b1, 4'hF); tick();
    end
    set_raster(0, 480, 1'b0, 1'b0, 4'h0); tick();
    park();
    if (w1c != 4'h0) wr(3'd1, {28'd0, w1c});
    else tick();
    for (int i = 0; i < NUM_OBS; i++) begin
      exp_ovl[i] = (cnt[i] > 65535) ? 65535 : cnt[i];
      if (cnt[i] >= int'(exp_thresh)) exp_hit[i] = 1'b1;
    end
    exp_frames = exp_frames + 16'd1;
  endtask

  initial begin
    bus.chipselect = 1'b0; bus.write = 1'b0; bus.read = 1'b0;
    bus.address = '0; bus.writedata = '0;
    reset_model();

    // Reset state
    tick(); tick();
    check("reset.readdata", bus.readdata, 32'd0);
    check("reset.irq", {31'd0, irq}, 32'd0);
    reset_n = 1'b1;
    tick();
    check_all("reset");

    // Enable mid-frame: overlap before the first start-of-frame is ignored
    set_raster(100, 100, 1'b1, 1'b1, 4'hF);
    wr(3'd0, 32'd3);
    for (int k = 0; k < 20; k++) tick();
    set_raster(0, 480, 1'b0, 1'b1, 4'hF); tick();
    park(); tick();
    rd(3'd2, rdat); check("partial.frame_cnt", rdat, 32'd0);
    rd(3'd3, rdat); check("partial.ovl0", rdat, 32'd0);

    // 10 overlap cycles on obstacle 0, threshold 4
    run_frame(10, 4'h1, 1'b0, -1, 4'h0);
    check_all("ovl10");

    // Software clear in a quiet cycle; irq falls one cycle later
    wr(3'd1, 32'd1);
    check("w1c.irq_hold", {31'd0, irq}, 32'd1);
    tick();
    check("w1c.irq_drop", {31'd0, irq}, 32'd0);

    // 3 cycles on obstacle 2 stays below threshold
    run_frame(3, 4'h4, 1'b0, -1, 4'h0);
    check_all("ovl3");

    // Only blanked overlap
    run_frame(0, 4'h0, 1'b0, -1, 4'h0);
    check_all("blank");

    // Randomized frames, including threshold 0 and a mid-frame threshold change
    for (int r = 0; r < 4; r++) begin
      wr(3'd7, (r == 0) ? 32'd0 : 32'($urandom_range(1, 60)));
      if ($urandom_range(0, 1) == 1) wr(3'd1, 32'($urandom_range(0, 15)));
      run_frame(200, 4'h0, 1'b1, (r == 2) ? $urandom_range(0, 60) : -1, 4'h0);
      check_all($sformatf("rand%0d", r));
    end

    // Clear racing a commit that sets the same bit
    wr(3'd1, 32'hF);
    wr(3'd7, 32'd4);
    run_frame(10, 4'h1, 1'b0, -1, 4'h1);
    rd(3'd1, rdat); check("w1c_vs_commit", rdat, 32'd1);
    check_all("w1c_vs_commit");

    // Saturation
    run_frame(70000, 4'h1, 1'b0, -1, 4'h0);
    check_all("saturate");

    // Disable mid-ACCUM: nothing committed, registers held
    park(); tick();
    set_raster(0, 0, 1'b1, 1'b0, 4'h0); tick();
    for (int k = 0; k < 5; k++) begin
      set_raster(20 + k, 50, 1'b1, 1'b1, 4'h1); tick();
    end
    wr(3'd0, 32'd2);
    for (int k = 0; k < 3; k++) tick();
    set_raster(0, 480, 1'b0, 1'b0, 4'h0); tick();
    park(); tick(); tick();
    check_all("disable");

    // Re-enable: the interrupted partial count must not leak into obstacle 0
    wr(3'd0, 32'd3);
    run_frame(5, 4'h2, 1'b0, -1, 4'h0);
    check_all("reenable");
    rd(3'd4, rdat);
    tick(); tick();
    check("readdata_hold", bus.readdata, 32'd5);

    // Asynchronous reset between clock edges
    #3 reset_n = 1'b0;
    #1;
    check("async.readdata", bus.readdata, 32'd0);
    check("async.irq", {31'd0, irq}, 32'd0);
    tick();
    reset_n = 1'b1;
    reset_model();
    tick();
    check_all("after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog so a stuck run still terminates with a report.
  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
